// File: rtl/alu_decoder_pkg.sv
// Shared encodings for the RV32I ALU-control decoder.
package ALUControl_pkg;

  localparam int unsigned CTRL_W   = 3;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned FUNCT3_W = 3;

  // ALU operation codes; 3'b100 and 3'b110 are never produced.
  typedef enum logic [CTRL_W-1:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    SLT = 3'b101,
    INV = 3'b111
  } ALUControl_t;

  // Operation classes coming from the main decoder.
  localparam logic [ALUOP_W-1:0] ALUOP_MEM = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_BR  = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_ALU = 2'b10;

  // funct3 values that select a legal ALU operation.
  localparam logic [FUNCT3_W-1:0] F3_ADDSUB = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_SLT    = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_OR     = 3'b110;
  localparam logic [FUNCT3_W-1:0] F3_AND    = 3'b111;

  // Decoder input bundle, used by stimulus generators.
  typedef struct packed {
    logic                op_5;
    logic [ALUOP_W-1:0]  ALUOp;
    logic [FUNCT3_W-1:0] funct3;
    logic                funct7_5;
  } ALUDecoder_Input;

endpackage

// File: rtl/alu_decoder.sv
// RV32I ALU-control decoder: combinational code, registered copy, sticky illegal flag.
module alu_decoder
  import ALUControl_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_OpCode_5,
  input  logic [ALUOP_W-1:0]  i_ALUOp,
  input  logic [FUNCT3_W-1:0] i_funct3,
  input  logic                i_funct7_5,
  output ALUControl_t         o_ALUControl,
  output logic                o_Illegal,
  output ALUControl_t         o_ALUControl_q,
  output logic                o_IllegalSticky
);

  // Decode operation class and funct fields into the ALU code; unsupported -> INV.
  always_comb begin
    o_ALUControl = INV;
    unique case (i_ALUOp)
      ALUOP_MEM: o_ALUControl = ADD;
      ALUOP_BR:  o_ALUControl = SUB;
      ALUOP_ALU: begin
        unique case (i_funct3)
          // Only R-type with funct7[5] subtracts; addi keeps ADD whatever funct7[5] is.
          F3_ADDSUB: o_ALUControl = (i_OpCode_5 && i_funct7_5) ? SUB : ADD;
          F3_SLT:    o_ALUControl = SLT;
          F3_OR:     o_ALUControl = OR;
          F3_AND:    o_ALUControl = AND;
          default:   o_ALUControl = INV;
        endcase
      end
      default:   o_ALUControl = INV;
    endcase
    o_Illegal = (o_ALUControl == INV);
  end

  // Registered copy of the code and sticky record of any illegal decode.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ALUControl_q  <= ADD;
      o_IllegalSticky <= 1'b0;
    end else begin
      o_ALUControl_q  <= o_ALUControl;
      o_IllegalSticky <= o_IllegalSticky | o_Illegal;
    end
  end

endmodule

// File: tb/tb_alu_decoder.sv
// Scoreboard bench for alu_decoder: driver queues expectations, monitors pop and compare.
module tb_alu_decoder;
  import ALUControl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op5;
  logic [1:0]  aluop;
  logic [2:0]  f3;
  logic        f75;
  ALUControl_t ctrl, ctrl_q;
  logic        ill, sticky;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] ctrl;
    logic       ill;
    logic       sticky;
  } exp_t;

  exp_t comb_q[$];
  exp_t reg_q[$];
  logic model_sticky = 1'b0;

  alu_decoder dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_OpCode_5     (op5),
    .i_ALUOp        (aluop),
    .i_funct3       (f3),
    .i_funct7_5     (f75),
    .o_ALUControl   (ctrl),
    .o_Illegal      (ill),
    .o_ALUControl_q (ctrl_q),
    .o_IllegalSticky(sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference table: funct3 -> code for the ALU class (7 = unsupported).
  function automatic logic [2:0] ref_decode(input logic o5, input logic [1:0] op,
                                            input logic [2:0] fn3, input logic fn7);
    int alu_tab[8] = '{0, 7, 5, 7, 7, 7, 3, 2};
    int code;
    if (op == 2'd0)      code = 0;
    else if (op == 2'd1) code = 1;
    else if (op == 2'd3) code = 7;
    else begin
      code = alu_tab[fn3];
      if (fn3 == 3'd0 && o5 && fn7) code = 1;
    end
    return 3'(code);
  endfunction

  // Drive one vector after a rising edge and queue what both monitors must see.
  task automatic apply(input logic o5, input logic [1:0] op, input logic [2:0] fn3, input logic fn7);
    exp_t e;
    @(posedge clk);
    #2;
    op5 = o5; aluop = op; f3 = fn3; f75 = fn7;
    e.ctrl = ref_decode(o5, op, fn3, fn7);
    e.ill  = (e.ctrl == 3'd7);
    model_sticky = model_sticky | e.ill;
    e.sticky = model_sticky;
    comb_q.push_back(e);
    reg_q.push_back(e);
  endtask

  // Combinational monitor: checks the decode mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (comb_q.size() > 0) begin
      e = comb_q.pop_front();
      chk("alu_control", 8'(ctrl), 8'(e.ctrl));
      chk("illegal", 8'(ill), 8'(e.ill));
    end
  end

  // Registered monitor: checks the captured code and sticky just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reg_q.size() > 0) begin
      e = reg_q.pop_front();
      chk("alu_control_q", 8'(ctrl_q), 8'(e.ctrl));
      chk("illegal_sticky", 8'(sticky), 8'(e.sticky));
    end
  end

  // Mid-cycle asynchronous reset, held across an edge with illegal input applied.
  task automatic reset_mid_cycle();
    @(posedge clk);
    #3;
    chk("sticky_before_reset", 8'(sticky), 8'(model_sticky));
    rst_n = 1'b0;
    aluop = 2'b11;
    #1;
    chk("rst_async_q", 8'(ctrl_q), 8'h00);
    chk("rst_async_sticky", 8'(sticky), 8'h00);
    chk("rst_comb_unaffected", 8'(ill), 8'h01);
    @(posedge clk);
    #1;
    chk("rst_wins_sticky", 8'(sticky), 8'h00);
    chk("rst_wins_q", 8'(ctrl_q), 8'h00);
    #2;
    aluop = 2'b00;
    model_sticky = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    ALUDecoder_Input v;
    rst_n = 1'b0; op5 = 1'b0; aluop = 2'b00; f3 = 3'b000; f75 = 1'b0;
    #1;
    chk("reset_q", 8'(ctrl_q), 8'h00);
    chk("reset_sticky", 8'(sticky), 8'h00);
    #12;
    rst_n = 1'b1;

    // Load/store and branch classes with funct3 swept.
    for (int i = 0; i < 8; i++) apply(1'(i & 1), 2'b00, 3'(i), 1'(i >> 1));
    for (int i = 0; i < 8; i++) apply(1'(i >> 2), 2'b01, 3'(i), 1'(i & 1));
    // ADD/SUB selection on op5/funct7_5.
    for (int i = 0; i < 4; i++) apply(1'(i >> 1), 2'b10, 3'b000, 1'(i & 1));
    apply(1'b0, 2'b10, 3'b010, 1'b0);
    apply(1'b1, 2'b10, 3'b110, 1'b0);
    apply(1'b1, 2'b10, 3'b111, 1'b1);
    // Illegal encodings, then back to legal to confirm sticky holds.
    apply(1'b1, 2'b10, 3'b001, 1'b0);
    apply(1'b0, 2'b00, 3'b000, 1'b0);
    apply(1'b1, 2'b11, 3'b000, 1'b1);
    apply(1'b0, 2'b01, 3'b000, 1'b0);

    reset_mid_cycle();
    apply(1'b0, 2'b01, 3'b000, 1'b0);

    // Randomized vectors against the reference table.
    for (int n = 0; n < 40; n++) begin
      v = ALUDecoder_Input'($urandom_range(0, 127));
      apply(v.op_5, v.ALUOp, v.funct3, v.funct7_5);
    end

    // Bounded drain of outstanding expectations.
    for (int c = 0; c < 10 && (comb_q.size() > 0 || reg_q.size() > 0); c++) @(posedge clk);
    #2;
    checks++;
    if (comb_q.size() > 0 || reg_q.size() > 0) begin
      failures++;
      $display("FAIL drain: pending comb=%0d reg=%0d expected 0", comb_q.size(), reg_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
